// File: rtl/prbs15_checker.sv
// PRBS15 (x^15+x^14+1) serial checker: self-synchronising SEED/HUNT/LOCKED loop
// with error pulse, saturating error count and optional bit count (PRBS15_CHECKER_BIT_CNT_EN).
module prbs15_checker #(
   parameter int LOCK_CNT   = 32,
   parameter int UNLOCK_ERR = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        prbs_i,
   input  logic        valid_i,
   input  logic        clear_i,
   output logic        locked_o,
   output logic        err_o,
   output logic [15:0] err_cnt_o,
   output logic [31:0] bit_cnt_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_CNT_L   = 8'(LOCK_CNT);
   localparam logic [6:0] UNLOCK_ERR_L = 7'(UNLOCK_ERR);

   state_t      r_state;
   state_t      w_next_state;
   logic [14:0] r_hist;
   logic [3:0]  r_fill;
   logic [7:0]  r_match;
   logic [5:0]  r_win_cnt;
   logic [6:0]  r_win_err;
   logic        r_err;
   logic [15:0] r_err_cnt;

   logic        w_exp;
   logic        w_mismatch;
   logic        w_hunt_ok;
   logic [7:0]  w_match_next;
   logic        w_lock_hit;
   logic [6:0]  w_win_err_next;
   logic        w_unlock;
   logic        w_err_now;

   // h[0] is the newest bit, so h[14]/h[13] are b[n]/b[n+1] for predicting b[n+15]
   assign w_exp          = r_hist[14] ^ r_hist[13];
   assign w_mismatch     = (prbs_i != w_exp);
   assign w_hunt_ok      = !w_mismatch && (r_hist != 15'd0);
   assign w_match_next   = r_match + 8'd1;
   assign w_lock_hit     = (w_match_next == LOCK_CNT_L);
   assign w_win_err_next = r_win_err + {6'd0, w_mismatch};
   assign w_unlock       = w_mismatch && (w_win_err_next >= UNLOCK_ERR_L);
   assign w_err_now      = valid_i && (r_state == ST_LOCKED) && w_mismatch;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_SEED;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (valid_i) begin
         case (r_state)
            ST_SEED: begin
               if (r_fill == 4'd14) w_next_state = ST_HUNT;
            end
            ST_HUNT: begin
               if (!w_hunt_ok)      w_next_state = ST_SEED;
               else if (w_lock_hit) w_next_state = ST_LOCKED;
            end
            ST_LOCKED: begin
               if (w_unlock) w_next_state = ST_SEED;
            end
            default: w_next_state = ST_SEED;
         endcase
      end
   end

   always_comb begin
      locked_o  = (r_state == ST_LOCKED);
      err_o     = r_err;
      err_cnt_o = r_err_cnt;
      state_o   = r_state;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_match   <= '0;
         r_win_cnt <= '0;
         r_win_err <= '0;
      end else if (valid_i) begin
         case (r_state)
            ST_SEED: begin
               r_hist  <= {r_hist[13:0], prbs_i};
               r_fill  <= (r_fill == 4'd14) ? 4'd0 : r_fill + 4'd1;
               r_match <= '0;
            end
            ST_HUNT: begin
               r_hist <= {r_hist[13:0], prbs_i};
               if (!w_hunt_ok || w_lock_hit) begin
                  r_fill  <= '0;
                  r_match <= '0;
               end else begin
                  r_match <= w_match_next;
               end
            end
            ST_LOCKED: begin
               // Flywheel on the prediction so a single flipped bit is a single error
               r_hist <= {r_hist[13:0], w_exp};
               if (w_unlock) begin
                  r_fill    <= '0;
                  r_match   <= '0;
                  r_win_cnt <= '0;
                  r_win_err <= '0;
               end else begin
                  r_win_cnt <= r_win_cnt + 6'd1;
                  r_win_err <= (r_win_cnt == 6'd63) ? 7'd0 : w_win_err_next;
               end
            end
            default: begin
               r_fill  <= '0;
               r_match <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_err_now;
         if (clear_i) begin
            r_err_cnt <= '0;
         end else if (w_err_now && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

`ifdef PRBS15_CHECKER_BIT_CNT_EN
   logic [31:0] r_bit_cnt;
   logic        w_bit_now;

   assign w_bit_now = valid_i && (r_state == ST_LOCKED);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bit_cnt <= '0;
      end else if (clear_i) begin
         r_bit_cnt <= '0;
      end else if (w_bit_now && (r_bit_cnt != 32'hFFFF_FFFF)) begin
         r_bit_cnt <= r_bit_cnt + 32'd1;
      end
   end

   assign bit_cnt_o = r_bit_cnt;
`else
   assign bit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prbs15_checker.sv
// Bench for prbs15_checker: directed PRBS15 streams with injected errors; err_o pulses
// are scored against an expected-count queue. Second instance (UNLOCK_ERR=64) covers saturation.
module tb_prbs15_checker;

   logic        clk = 1'b0;
   logic        rst_i, prbs_i, valid_i, clear_i;
   logic        locked_o, err_o;
   logic [15:0] err_cnt_o;
   logic [31:0] bit_cnt_o;
   logic [1:0]  state_o;

   logic        s_rst, s_prbs, s_valid, s_clear;
   logic        s_locked, s_err;
   logic [15:0] s_err_cnt;
   logic [31:0] s_bit_cnt;
   logic [1:0]  s_state;

   logic [15:0] exp_q[$];
   logic [15:0] sat_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [14:0] g;
   int          exp_err;
   int          exp_sat;

`ifdef PRBS15_CHECKER_BIT_CNT_EN
   localparam bit BITCNT_ON = 1'b1;
`else
   localparam bit BITCNT_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   prbs15_checker dut (
      .clk_i(clk), .rst_i(rst_i), .prbs_i(prbs_i), .valid_i(valid_i), .clear_i(clear_i),
      .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .bit_cnt_o(bit_cnt_o),
      .state_o(state_o)
   );

   prbs15_checker #(.LOCK_CNT(32), .UNLOCK_ERR(64)) dut_sat (
      .clk_i(clk), .rst_i(s_rst), .prbs_i(s_prbs), .valid_i(s_valid), .clear_i(s_clear),
      .locked_o(s_locked), .err_o(s_err), .err_cnt_o(s_err_cnt), .bit_cnt_o(s_bit_cnt),
      .state_o(s_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: every err_o pulse must match the next expected error count
   always @(negedge clk) begin
      if (err_o === 1'b1) begin
         if (exp_q.size() == 0) check("err_pulse_unexpected", 32'd1, 32'd0);
         else check("err_cnt_at_pulse", {16'd0, err_cnt_o}, {16'd0, exp_q.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (s_err === 1'b1) begin
         if (sat_q.size() == 0) check("sat_pulse_unexpected", 32'd1, 32'd0);
         else check("sat_err_cnt_at_pulse", {16'd0, s_err_cnt}, {16'd0, sat_q.pop_front()});
      end
   end

   task automatic next_clean(output logic b);
      b = g[14] ^ g[13];
      g = {g[13:0], b};
   endtask

   task automatic send(input int sel, input logic b, input logic v, input logic c);
      @(negedge clk);
      if (sel == 0) begin
         rst_i = 1'b0; prbs_i = b; valid_i = v; clear_i = c;
      end else begin
         s_rst = 1'b0; s_prbs = b; s_valid = v; s_clear = c;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      valid_i = 1'b0; clear_i = 1'b0; rst_i = 1'b0; prbs_i = 1'($urandom_range(0, 1));
      s_valid = 1'b0; s_clear = 1'b0; s_prbs = 1'($urandom_range(0, 1));
   endtask

   task automatic rst_pulse(input int sel, input logic v);
      @(negedge clk);
      if (sel == 0) begin
         rst_i = 1'b1; valid_i = v; clear_i = 1'b0; prbs_i = 1'($urandom_range(0, 1));
         exp_err = 0;
      end else begin
         s_rst = 1'b1; s_valid = v; s_clear = 1'b0; s_prbs = 1'($urandom_range(0, 1));
         exp_sat = 0;
      end
      @(negedge clk);
      rst_i = 1'b0; valid_i = 1'b0; s_rst = (sel == 0) ? s_rst : 1'b0; s_valid = 1'b0;
   endtask

   task automatic send_clean(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         next_clean(b);
         send(0, b, 1'b1, 1'b0);
      end
   endtask

   task automatic send_err(input logic c);
      logic b;
      next_clean(b);
      send(0, ~b, 1'b1, c);
      exp_err = c ? 0 : ((exp_err < 65535) ? exp_err + 1 : 65535);
      exp_q.push_back(16'(exp_err));
   endtask

   task automatic expect_lock_at_47(input string tag);
      send_clean(46);
      idle();
      check({tag, "_unlocked_at_46"}, {31'd0, locked_o}, 32'd0);
      send_clean(1);
      idle();
      check({tag, "_locked_at_47"}, {31'd0, locked_o}, 32'd1);
   endtask

   initial begin
      logic b;
      int   n, k;
      rst_i = 1'b1; prbs_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
      s_rst = 1'b1; s_prbs = 1'b0; s_valid = 1'b0; s_clear = 1'b0;
      exp_err = 0; exp_sat = 0;
      repeat (3) @(negedge clk);

      // Reset state
      rst_pulse(0, 1'b1);
      check("rst_locked", {31'd0, locked_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);
      check("rst_bit_cnt", bit_cnt_o, 32'd0);
      check("rst_state", {30'd0, state_o}, 32'd0);

      // Clean stream locks on bit 47; one flipped bit gives one error
      g = 15'h7FFF;
      expect_lock_at_47("clean");
      check("clean_err_cnt", {16'd0, err_cnt_o}, 32'd0);
      send_clean(10);
      send_err(1'b0);
      send_clean(10);
      idle();
      check("single_locked", {31'd0, locked_o}, 32'd1);
      check("single_err_cnt", {16'd0, err_cnt_o}, 32'd1);
      check("single_bit_cnt", bit_cnt_o, BITCNT_ON ? 32'd21 : 32'd0);

      // Eight errors in one window drop lock, then relock after 47 clean bits
      rst_pulse(0, 1'b0);
      g = 15'h7FFF;
      expect_lock_at_47("burst_pre");
      for (int i = 0; i < 8; i++) begin
         send_err(1'b0);
         if (i < 7) send_clean(2);
      end
      idle();
      check("burst_unlocked", {31'd0, locked_o}, 32'd0);
      check("burst_err_cnt", {16'd0, err_cnt_o}, 32'd8);
      check("burst_bit_cnt", bit_cnt_o, BITCNT_ON ? 32'd22 : 32'd0);
      expect_lock_at_47("burst_relock");
      check("burst_err_cnt_kept", {16'd0, err_cnt_o}, 32'd8);

      // All-zero stream never locks and never flags an error
      rst_pulse(0, 1'b0);
      for (int i = 0; i < 200; i++) send(0, 1'b0, 1'b1, 1'b0);
      idle();
      check("zero_locked", {31'd0, locked_o}, 32'd0);
      check("zero_err_cnt", {16'd0, err_cnt_o}, 32'd0);

      // 50% valid duty, then reset while locked and a full relock
      rst_pulse(0, 1'b0);
      g = 15'h7FFF;
      for (int i = 0; i < 47; i++) begin
         send(0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         next_clean(b);
         send(0, b, 1'b1, 1'b0);
         if (i == 45) begin
            idle();
            check("toggle_unlocked_at_46", {31'd0, locked_o}, 32'd0);
         end
      end
      idle();
      check("toggle_locked_at_47", {31'd0, locked_o}, 32'd1);
      send_clean(3);
      send_err(1'b0);
      send_clean(2);
      idle();
      check("toggle_err_cnt", {16'd0, err_cnt_o}, 32'd1);
      rst_pulse(0, 1'b1);
      check("midlock_rst_locked", {31'd0, locked_o}, 32'd0);
      check("midlock_rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);
      check("midlock_rst_bit_cnt", bit_cnt_o, 32'd0);
      check("midlock_rst_err", {31'd0, err_o}, 32'd0);
      expect_lock_at_47("after_rst");

      // clear_i beats a simultaneous error and leaves lock alone
      send_err(1'b1);
      send_clean(3);
      idle();
      check("clear_with_err_cnt", {16'd0, err_cnt_o}, 32'd0);
      send_err(1'b0);
      send_clean(1);
      idle();
      check("post_clear_err_cnt", {16'd0, err_cnt_o}, 32'd1);
      next_clean(b);
      send(0, b, 1'b1, 1'b1);
      idle();
      check("clear_err_cnt", {16'd0, err_cnt_o}, 32'd0);
      check("clear_bit_cnt", bit_cnt_o, 32'd0);
      check("clear_locked", {31'd0, locked_o}, 32'd1);

      // Saturation: 63 errors per 64-bit window stays under UNLOCK_ERR=64
      rst_pulse(1, 1'b0);
      g = 15'h7FFF;
      for (int i = 0; i < 47; i++) begin
         next_clean(b);
         send(1, b, 1'b1, 1'b0);
      end
      idle();
      check("sat_locked", {31'd0, s_locked}, 32'd1);
      n = 0;
      k = 0;
      while (n < 32'h0000FFFE + 3) begin
         next_clean(b);
         if ((k % 64) != 0) begin
            send(1, ~b, 1'b1, 1'b0);
            n++;
            exp_sat = (exp_sat < 65535) ? exp_sat + 1 : 65535;
            sat_q.push_back(16'(exp_sat));
         end else begin
            send(1, b, 1'b1, 1'b0);
         end
         k++;
      end
      idle();
      check("sat_err_cnt_hold", {16'd0, s_err_cnt}, 32'h0000FFFF);
      check("sat_still_locked", {31'd0, s_locked}, 32'd1);
      send(1, 1'b0, 1'b0, 1'b1);
      idle();
      check("sat_clear", {16'd0, s_err_cnt}, 32'd0);
      check("sat_clear_locked", {31'd0, s_locked}, 32'd1);

      repeat (3) idle();
      check("exp_q_drained", exp_q.size(), 32'd0);
      check("sat_q_drained", sat_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/prbs15_checker.md
PRBS15_CHECKER -- requirements
Module: prbs15_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32, meaning consecutive matching bits in HUNT required to enter LOCKED (range 1..255).
REQ-002 Parameter UNLOCK_ERR, default 8, meaning errors within one 64-bit window that force loss of lock (range 1..64).
REQ-003 clk_i  input  1  clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 prbs_i  input  1  received serial PRBS15 bit.
REQ-006 valid_i  input  1  prbs_i qualifier; the checker ignores prbs_i while low.
REQ-007 clear_i  input  1  synchronous zeroing of err_cnt_o and bit_cnt_o.
REQ-008 locked_o  output  1  high while in LOCKED.
REQ-009 err_o  output  1  single-cycle pulse per detected bit error.
REQ-010 err_cnt_o  output  16  saturating error count.
REQ-011 bit_cnt_o  output  32  saturating count of bits checked in LOCKED.

Function
REQ-012 Polynomial x^15+x^14+1; 15-bit history h, h[0] newest; expected bit = h[14] XOR h[13]; stream satisfies b[n+15] = b[n] XOR b[n+1].
REQ-013 State machine: SEED, HUNT, LOCKED; all transitions occur only on valid_i cycles, except reset.
REQ-014 SEED: shift prbs_i into h; fill counter 0..14; go to HUNT after the 15th valid bit.
REQ-015 HUNT: compare prbs_i to expected; shift prbs_i into h; on match, increment match counter; on mismatch, go to SEED with fill and match counters zeroed.
REQ-016 HUNT: if h is all-zero, treat as mismatch (no lock on all-zero stream).
REQ-017 HUNT -> LOCKED on the valid bit making match count equal LOCK_CNT; locked_o high the following cycle.
REQ-018 LOCKED: shift expected bit (not prbs_i) into h, so one flipped input bit yields exactly one error.
REQ-019 LOCKED: mismatch -> err_o high exactly one cycle after the sampled bit; err_cnt_o increments same cycle.
REQ-020 LOCKED: each valid bit increments bit_cnt_o and a 6-bit window counter; window error count clears on window wrap (64th bit).
REQ-021 Window error count reaching UNLOCK_ERR -> SEED next cycle; locked_o low; counters zeroed except err_cnt_o/bit_cnt_o.
REQ-022 The bit that completes UNLOCK_ERR and the window wrap in the same cycle -> unlock takes priority.
REQ-023 err_cnt_o saturates at 0xFFFF; bit_cnt_o saturates at 0xFFFFFFFF; neither wraps.
REQ-024 clear_i zeroes both counters; clear_i with a simultaneous error -> result 0 (clear wins); lock state unaffected.
REQ-025 err_o is never asserted outside LOCKED.

Reset
REQ-026 rst_i high: state SEED, h=0, all internal counters 0, locked_o=0, err_o=0, err_cnt_o=0, bit_cnt_o=0.
REQ-027 Reset asserted mid-lock takes effect next edge; relock requires the full 15+LOCK_CNT valid bits.

Configuration
REQ-028 Macro PRBS15_CHECKER_BIT_CNT_EN defined: bit_cnt_o counter implemented per REQ-020/023.
REQ-029 Macro PRBS15_CHECKER_BIT_CNT_EN undefined: no bit counter register; bit_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-030 Clean stream from generator seeded 0x7FFF, valid_i always high -> locked_o rises one cycle after valid bit 47, err_cnt_o stays 0.
REQ-031 Locked, invert one bit -> exactly one err_o pulse, err_cnt_o=1, locked_o stays high.
REQ-032 Locked, invert 8 bits within 64 bits -> locked_o falls after 8th error, err_cnt_o=8, relock after 47 further clean bits.
REQ-033 All-zero input for 200 valid bits -> locked_o never rises, err_o never pulses.
REQ-034 Force err_cnt_o to 0xFFFE via continuous errors below unlock threshold, then 3 more errors -> holds 0xFFFF; clear_i -> 0 next cycle.
REQ-035 valid_i toggling 50% on clean stream -> lock after 47 valid bits; rst_i pulse while locked -> all outputs 0 next cycle.
